// File: rtl/alu_seq_unit.sv
// alu_seq_unit: multi-cycle ALU execution unit.
// Logic ops (AND/OR/XOR) finish in one cycle; ADD/SUB/SLT go through a
// CHUNK-bit slice adder, LSB slice first, one slice per clock.
// Optional feature macro: ALU_ZERO_FLAG_EN adds the registered Zero output.
module alu_seq_unit #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             InValid,
    output logic             InReady,
    input  logic [3:0]       Operation,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] Result
`ifdef ALU_ZERO_FLAG_EN
    ,
    output logic             Zero
`endif
);

    localparam int N    = WIDTH / CHUNK;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b1100;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ARITH = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [3:0]        op_r;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;          // already inverted for SUB/SLT
    logic [IDXW-1:0]   idx_r;
    logic              carry_r;
    logic [WIDTH-1:0]  result_r;
    logic              out_valid_r;

    logic              accept_s;
    logic              is_arith_s;
    logic              is_sub_s;
    logic [WIDTH-1:0]  logic_res_s;
    logic [CHUNK-1:0]  a_slice_s;
    logic [CHUNK-1:0]  b_slice_s;
    logic [CHUNK:0]    sum_s;
    logic              last_s;
    logic              ovf_s;
    logic              lt_s;
    logic [WIDTH-1:0]  slice_res_s;
    logic [WIDTH-1:0]  arith_res_s;

    // Single-cycle result for logic ops; unsupported codes yield zero.
    function automatic logic [WIDTH-1:0] logic_result(input logic [3:0] op,
                                                      input logic [WIDTH-1:0] a,
                                                      input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            default: r = {WIDTH{1'b0}};
        endcase
        return r;
    endfunction

    assign InReady  = (state_r == IDLE);
    assign OutValid = out_valid_r;
    assign Result   = result_r;

    // Request decode: accept condition and operation class.
    always_comb begin
        accept_s    = InValid && (state_r == IDLE);
        is_sub_s    = (Operation == OP_SUB) || (Operation == OP_SLT);
        is_arith_s  = (Operation == OP_ADD) || is_sub_s;
        logic_res_s = logic_result(Operation, SrcA, SrcB);
    end

    // Slice adder plus SLT sign/overflow resolution on the last slice.
    always_comb begin
        a_slice_s   = a_r[int'(idx_r) * CHUNK +: CHUNK];
        b_slice_s   = b_r[int'(idx_r) * CHUNK +: CHUNK];
        sum_s       = {1'b0, a_slice_s} + {1'b0, b_slice_s} + {{CHUNK{1'b0}}, carry_r};
        last_s      = (idx_r == IDXW'(N - 1));
        slice_res_s = result_r;
        slice_res_s[int'(idx_r) * CHUNK +: CHUNK] = sum_s[CHUNK-1:0];
        // b_r holds ~B here, so the original B sign is ~b_r[MSB]
        ovf_s       = (a_r[WIDTH-1] != ~b_r[WIDTH-1]) && (sum_s[CHUNK-1] != a_r[WIDTH-1]);
        lt_s        = sum_s[CHUNK-1] ^ ovf_s;
        if (last_s && (op_r == OP_SLT)) begin
            arith_res_s = {{(WIDTH-1){1'b0}}, lt_s};
        end else begin
            arith_res_s = slice_res_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (InValid) begin
                    state_s = is_arith_s ? ARITH : DONE;
                end else begin
                    state_s = IDLE;
                end
            end
            ARITH: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = ARITH;
                end
            end
            DONE: begin
                if (OutReady) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Datapath registers: operand capture, slice accumulation, result/valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_r        <= 4'b0000;
            a_r         <= {WIDTH{1'b0}};
            b_r         <= {WIDTH{1'b0}};
            idx_r       <= {IDXW{1'b0}};
            carry_r     <= 1'b0;
            result_r    <= {WIDTH{1'b0}};
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        op_r    <= Operation;
                        a_r     <= SrcA;
                        b_r     <= is_sub_s ? ~SrcB : SrcB;
                        idx_r   <= {IDXW{1'b0}};
                        carry_r <= is_sub_s;
                        if (is_arith_s) begin
                            result_r    <= {WIDTH{1'b0}};
                            out_valid_r <= 1'b0;
                        end else begin
                            result_r    <= logic_res_s;
                            out_valid_r <= 1'b1;
                        end
                    end
                end
                ARITH: begin
                    result_r <= arith_res_s;
                    carry_r  <= sum_s[CHUNK];
                    if (last_s) begin
                        idx_r       <= {IDXW{1'b0}};
                        out_valid_r <= 1'b1;
                    end else begin
                        idx_r <= idx_r + IDXW'(1);
                    end
                end
                DONE: begin
                    if (OutReady) begin
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef ALU_ZERO_FLAG_EN
    logic zero_r;
    assign Zero = zero_r;

    // Zero flag, written on the same edge as the final Result value.
    always_ff @(posedge clk) begin
        if (reset) begin
            zero_r <= 1'b0;
        end else if (accept_s && !is_arith_s) begin
            zero_r <= (logic_res_s == {WIDTH{1'b0}});
        end else if ((state_r == ARITH) && last_s) begin
            zero_r <= (arith_res_s == {WIDTH{1'b0}});
        end
    end
`endif

endmodule
